// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the register-file write port
// and tracks per-register outstanding writes for decode hazard stalls.
module wb_arbiter #(
   parameter int XLEN       = 64,
   parameter int PEND_W     = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            alu_valid_i,
   input  logic [4:0]      alu_rd_i,
   input  logic [XLEN-1:0] alu_data_i,
   output logic            alu_ready_o,
   input  logic            lsu_valid_i,
   input  logic [4:0]      lsu_rd_i,
   input  logic [XLEN-1:0] lsu_data_i,
   output logic            lsu_ready_o,
   input  logic            iss_valid_i,
   input  logic [4:0]      iss_rd_i,
   output logic            reg_wen_o,
   output logic [4:0]      reg_waddr_o,
   output logic [XLEN-1:0] reg_wdata_o,
   output logic [31:0]     busy_o,
   output logic            sb_err_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0]     starve_q, starve_d;
   logic              wen_q, wen_d;
   logic [4:0]        waddr_q, waddr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [PEND_W-1:0] cnt_q [32];
   logic [PEND_W-1:0] cnt_d [32];
   logic              err_q, err_d;

   logic              force_alu;
   logic              alu_xfer;
   logic              lsu_xfer;
   logic              wr;
   logic [4:0]        xfer_rd;
   logic [XLEN-1:0]   xfer_data;
   logic [31:0]       inc_vec;
   logic [31:0]       dec_vec;

   // Forcing only while ALU is waiting avoids idling the LSU for nothing.
   always_comb begin
      force_alu   = alu_valid_i && (starve_q == SW'(STARVE_MAX));
      lsu_ready_o = !force_alu;
      alu_ready_o = force_alu || !lsu_valid_i;
      lsu_xfer    = lsu_valid_i && lsu_ready_o;
      alu_xfer    = alu_valid_i && alu_ready_o;
      xfer_rd     = lsu_xfer ? lsu_rd_i : alu_rd_i;
      xfer_data   = lsu_xfer ? lsu_data_i : alu_data_i;
      wr          = (lsu_xfer || alu_xfer) && (xfer_rd != 5'd0);
   end

   always_comb begin
      starve_d = starve_q;
      if (alu_xfer || !alu_valid_i) begin
         starve_d = '0;
      end else begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_comb begin
      wen_d   = wr;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (wr) begin
         waddr_d = xfer_rd;
         wdata_d = xfer_data;
      end
   end

   always_comb begin
      inc_vec = iss_valid_i ? (32'd1 << iss_rd_i) : 32'd0;
      inc_vec[0] = 1'b0;
      dec_vec = wr ? (32'd1 << xfer_rd) : 32'd0;
   end

   // A same-cycle set and retire on one register cancel out.
   always_comb begin
      err_d = err_q;
      for (int n = 0; n < 32; n++) begin
         cnt_d[n] = cnt_q[n];
         if (inc_vec[n] && !dec_vec[n]) begin
            if (&cnt_q[n]) err_d = 1'b1;
            else cnt_d[n] = cnt_q[n] + PEND_W'(1);
         end else if (dec_vec[n] && !inc_vec[n]) begin
            if (cnt_q[n] == '0) err_d = 1'b1;
            else cnt_d[n] = cnt_q[n] - PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_q <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         for (int n = 0; n < 32; n++) cnt_q[n] <= '0;
      end else begin
         starve_q <= starve_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         for (int n = 0; n < 32; n++) cnt_q[n] <= cnt_d[n];
      end
   end

   always_comb begin
      for (int n = 0; n < 32; n++) busy_o[n] = |cnt_q[n];
      busy_o[0] = 1'b0;
   end

   assign reg_wen_o   = wen_q;
   assign reg_waddr_o = waddr_q;
   assign reg_wdata_o = wdata_q;
   assign sb_err_o    = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: expected writes are queued when
// stimulus is driven and compared when the register-file port fires.
module tb_wb_arbiter;

   localparam int XLEN = 64;
   localparam int SMAX = 4;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            alu_valid_i;
   logic [4:0]      alu_rd_i;
   logic [XLEN-1:0] alu_data_i;
   logic            alu_ready_o;
   logic            lsu_valid_i;
   logic [4:0]      lsu_rd_i;
   logic [XLEN-1:0] lsu_data_i;
   logic            lsu_ready_o;
   logic            iss_valid_i;
   logic [4:0]      iss_rd_i;
   logic            reg_wen_o;
   logic [4:0]      reg_waddr_o;
   logic [XLEN-1:0] reg_wdata_o;
   logic [31:0]     busy_o;
   logic            sb_err_o;

   int checks = 0;
   int errors = 0;

   logic [68:0] exp_q [$];
   logic [68:0] exp_e;

   wb_arbiter #(.XLEN(XLEN), .PEND_W(2), .STARVE_MAX(SMAX)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .alu_valid_i (alu_valid_i),
      .alu_rd_i    (alu_rd_i),
      .alu_data_i  (alu_data_i),
      .alu_ready_o (alu_ready_o),
      .lsu_valid_i (lsu_valid_i),
      .lsu_rd_i    (lsu_rd_i),
      .lsu_data_i  (lsu_data_i),
      .lsu_ready_o (lsu_ready_o),
      .iss_valid_i (iss_valid_i),
      .iss_rd_i    (iss_rd_i),
      .reg_wen_o   (reg_wen_o),
      .reg_waddr_o (reg_waddr_o),
      .reg_wdata_o (reg_wdata_o),
      .busy_o      (busy_o),
      .sb_err_o    (sb_err_o)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every register-file write must match the queue head.
   always @(negedge clk) begin
      if (reg_wen_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected got %0d/%h exp none", reg_waddr_o, reg_wdata_o);
         end else begin
            exp_e = exp_q.pop_front();
            if ({reg_waddr_o, reg_wdata_o} !== exp_e) begin
               errors++;
               $display("FAIL wr_data got %0d/%h exp %0d/%h",
                        reg_waddr_o, reg_wdata_o, exp_e[68:64], exp_e[63:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid_i = 1'b0;
      lsu_valid_i = 1'b0;
      iss_valid_i = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      iss_valid_i = 1'b1;
      iss_rd_i    = rd;
      tick();
      iss_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 64'hA5;
      iss_valid_i = 1'b1; iss_rd_i = 5'd1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (reg_wen_o !== 1'b0) begin
            errors++; $display("FAIL rst_wen got %b exp 0", reg_wen_o);
         end
      end
      rst_i = 1'b0;
      idle();
      tick();
      checks++;
      if ({reg_wen_o, busy_o, sb_err_o} !== 34'd0) begin
         errors++;
         $display("FAIL rst_release got wen=%b busy=%h err=%b exp 0/0/0",
                  reg_wen_o, busy_o, sb_err_o);
      end
   endtask

   task automatic test_single_alu();
      issue(5'd5);
      checks++;
      if (busy_o[5] !== 1'b1) begin
         errors++; $display("FAIL single_busy_set got %b exp 1", busy_o[5]);
      end
      alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 64'hDEAD_BEEF;
      #1;
      checks++;
      if (alu_ready_o !== 1'b1) begin
         errors++; $display("FAIL single_ready got %b exp 1", alu_ready_o);
      end
      exp_q.push_back({5'd5, 64'hDEAD_BEEF});
      tick();
      alu_valid_i = 1'b0;
      checks++;
      if ({reg_wen_o, busy_o[5]} !== 2'b10) begin
         errors++;
         $display("FAIL single_same_cycle got wen=%b busy5=%b exp 1/0", reg_wen_o, busy_o[5]);
      end
      tick();
      checks++;
      if (reg_wen_o !== 1'b0 || reg_wdata_o !== 64'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_hold got wen=%b data=%h exp 0/deadbeef", reg_wen_o, reg_wdata_o);
      end
   endtask

   task automatic test_collision();
      issue(5'd3);
      issue(5'd4);
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_data_i = 64'h11;
      alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = 64'h22;
      #1;
      checks++;
      if ({lsu_ready_o, alu_ready_o} !== 2'b10) begin
         errors++;
         $display("FAIL coll_ready got lsu=%b alu=%b exp 1/0", lsu_ready_o, alu_ready_o);
      end
      exp_q.push_back({5'd3, 64'h11});
      tick();
      lsu_valid_i = 1'b0;
      checks++;
      if (reg_waddr_o !== 5'd3) begin
         errors++; $display("FAIL coll_first got %0d exp 3", reg_waddr_o);
      end
      #1;
      checks++;
      if (alu_ready_o !== 1'b1) begin
         errors++; $display("FAIL coll_alu_ready got %b exp 1", alu_ready_o);
      end
      exp_q.push_back({5'd4, 64'h22});
      tick();
      alu_valid_i = 1'b0;
      checks++;
      if (reg_waddr_o !== 5'd4) begin
         errors++; $display("FAIL coll_second got %0d exp 4", reg_waddr_o);
      end
      tick();
      checks++;
      if (busy_o[4:3] !== 2'b00) begin
         errors++; $display("FAIL coll_busy got %b exp 00", busy_o[4:3]);
      end
   endtask

   task automatic test_starvation();
      int          ms;
      bit          alu_pend;
      int          forced_at;
      logic [4:0]  nrd;
      for (int i = 0; i < 9; i++) issue(5'(10 + i));
      issue(5'd20);
      ms = 0; alu_pend = 1'b1; forced_at = -1; nrd = 5'd10;
      alu_valid_i = 1'b1; alu_rd_i = 5'd20; alu_data_i = 64'hA1A1;
      lsu_valid_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         lsu_rd_i   = nrd;
         lsu_data_i = 64'(100 + c);
         alu_valid_i = alu_pend;
         #1;
         checks++;
         if (alu_pend && ms == SMAX) begin
            if ({lsu_ready_o, alu_ready_o} !== 2'b01) begin
               errors++;
               $display("FAIL starve_force c=%0d got lsu=%b alu=%b exp 0/1",
                        c, lsu_ready_o, alu_ready_o);
            end
            exp_q.push_back({5'd20, 64'hA1A1});
            forced_at = c; alu_pend = 1'b0; ms = 0;
         end else begin
            if ({lsu_ready_o, alu_ready_o} !== {1'b1, 1'b0}) begin
               errors++;
               $display("FAIL starve_lsu c=%0d got lsu=%b alu=%b exp 1/0",
                        c, lsu_ready_o, alu_ready_o);
            end
            exp_q.push_back({nrd, 64'(100 + c)});
            nrd = nrd + 5'd1;
            if (alu_pend) ms++;
         end
         tick();
         checks++;
         if (reg_wen_o !== 1'b1) begin
            errors++; $display("FAIL starve_wen c=%0d got %b exp 1", c, reg_wen_o);
         end
      end
      idle();
      checks++;
      if (forced_at != SMAX) begin
         errors++; $display("FAIL starve_cycle got %0d exp %0d", forced_at, SMAX);
      end
      tick();
      checks++;
      if (busy_o !== 32'd0) begin
         errors++; $display("FAIL starve_busy got %h exp 0", busy_o);
      end
   endtask

   task automatic test_x0_same_cycle();
      alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 64'h55;
      #1;
      checks++;
      if (alu_ready_o !== 1'b1) begin
         errors++; $display("FAIL x0_ready got %b exp 1", alu_ready_o);
      end
      tick();
      alu_valid_i = 1'b0;
      checks++;
      if (reg_wen_o !== 1'b0 || busy_o !== 32'd0) begin
         errors++; $display("FAIL x0_wen got %b busy=%h exp 0/0", reg_wen_o, busy_o);
      end
      issue(5'd7);
      iss_valid_i = 1'b1; iss_rd_i = 5'd7;
      alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 64'h77;
      exp_q.push_back({5'd7, 64'h77});
      tick();
      idle();
      checks++;
      if ({reg_wen_o, busy_o[7], sb_err_o} !== 3'b110) begin
         errors++;
         $display("FAIL same_cycle got wen=%b busy7=%b err=%b exp 1/1/0",
                  reg_wen_o, busy_o[7], sb_err_o);
      end
      alu_valid_i = 1'b1; alu_data_i = 64'h78;
      exp_q.push_back({5'd7, 64'h78});
      tick();
      alu_valid_i = 1'b0;
      checks++;
      if (busy_o[7] !== 1'b0) begin
         errors++; $display("FAIL same_cycle_clear got %b exp 0", busy_o[7]);
      end
   endtask

   task automatic test_error();
      for (int i = 0; i < 3; i++) issue(5'd9);
      checks++;
      if (sb_err_o !== 1'b0) begin
         errors++; $display("FAIL err_early got %b exp 0", sb_err_o);
      end
      issue(5'd9);
      checks++;
      if ({sb_err_o, busy_o[9]} !== 2'b11) begin
         errors++; $display("FAIL err_sat got err=%b busy9=%b exp 1/1", sb_err_o, busy_o[9]);
      end
      for (int i = 0; i < 3; i++) begin
         alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 64'(900 + i);
         exp_q.push_back({5'd9, 64'(900 + i)});
         tick();
         alu_valid_i = 1'b0;
         checks++;
         if (busy_o[9] !== (i < 2)) begin
            errors++; $display("FAIL err_drain i=%0d got %b exp %b", i, busy_o[9], i < 2);
         end
      end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      checks++;
      if (sb_err_o !== 1'b0) begin
         errors++; $display("FAIL err_rst got %b exp 0", sb_err_o);
      end
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_data_i = 64'h2222;
      exp_q.push_back({5'd2, 64'h2222});
      tick();
      lsu_valid_i = 1'b0;
      tick();
      checks++;
      if ({sb_err_o, busy_o[2]} !== 2'b10) begin
         errors++; $display("FAIL err_under got err=%b busy2=%b exp 1/0", sb_err_o, busy_o[2]);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      idle();
      alu_rd_i = '0; alu_data_i = '0;
      lsu_rd_i = '0; lsu_data_i = '0;
      iss_rd_i = '0;
      test_reset();
      test_single_alu();
      test_collision();
      test_starvation();
      test_x0_same_cycle();
      test_error();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL queue_drain got %0d left exp 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
